// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants used by the key-scheduling (ksa) and
// keystream (prga) stages of the decryption datapath.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int KEY_BYTES = 3;
  localparam int S_DEPTH   = 256;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD_I,
    CAP_I,
    CAP_J,
    WR_J,
    FINISH
  } ksa_state_t;

endpackage

// File: rtl/ksa.sv
// RC4 key scheduling: fills S with the identity permutation and then runs
// the KSA swap loop over the shared synchronous-read S memory.
module ksa
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      s_addr,
  input  byte_t                  s_rddata,
  output byte_t                  s_wrdata,
  output logic                   s_wren
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  // Handshake: en is taken only while rdy=1 (IDLE); the key is captured on
  // that same edge and rdy drops the following cycle until FINISH completes.
  ksa_state_t               state_q, state_d;
  logic [ADDR_W-1:0]        i_q, i_d;
  byte_t                    j_q, j_d;
  logic [KIDX_W-1:0]        kidx_q, kidx_d;
  byte_t                    si_q, si_d;
  logic [8*KEY_BYTES-1:0]   key_q, key_d;
  byte_t                    key_byte;
  byte_t                    jn;

  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KIDX_W'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  // jn uses the live read data so S[jn] can be addressed in the same cycle.
  assign jn = j_q + s_rddata + key_byte;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    kidx_d   = kidx_q;
    si_d     = si_q;
    key_d    = key_q;
    rdy      = 1'b0;
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;

    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          key_d   = key;
          i_d     = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        s_addr   = i_q;
        s_wrdata = byte_t'(i_q);
        s_wren   = 1'b1;
        i_d      = i_q + 1'b1;
        if (i_q == '1) begin
          j_d     = '0;
          kidx_d  = '0;
          state_d = RD_I;
        end
      end
      RD_I: begin
        s_addr  = i_q;
        state_d = CAP_I;
      end
      CAP_I: begin
        si_d    = s_rddata;
        j_d     = jn;
        s_addr  = ADDR_W'(jn);
        state_d = CAP_J;
      end
      CAP_J: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        s_addr   = ADDR_W'(j_q);
        s_wrdata = si_q;
        s_wren   = 1'b1;
        kidx_d   = (kidx_q == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
        if (i_q == '1) begin
          state_d = FINISH;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = RD_I;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: table of keys with hand-computed first swaps,
// a software RC4 KSA scoreboard, and hand-written handshake/reset sequences.
module tb_ksa;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  ksa dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- S memory model (synchronous read) ----------------
  logic [7:0] mem [256];
  always @(posedge clk) begin
    s_rddata <= mem[s_addr];
    if (s_wren) mem[s_addr] <= s_wrdata;
  end

  // ---------------- monitor ----------------
  logic [15:0] wr_log [$];
  int          busy_cnt;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_wren) wr_log.push_back({s_addr, s_wrdata});
      if (!rdy) busy_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  logic [7:0]  model_s [256];
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_run(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] j, t, kb;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      s[i] = 8'(i);
      exp_q.push_back({8'(i), 8'(i)});
    end
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j = j + s[i] + kb;
      t = s[i];
      exp_q.push_back({8'(i), s[j]});
      s[i] = s[j];
      exp_q.push_back({j, t});
      s[j] = t;
    end
    for (int i = 0; i < 256; i++) model_s[i] = s[i];
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic [23:0] k);
    busy_cnt = 0;
    wr_log.delete();
    key = k;
    en  = 1'b1;
    tick();
    en  = 1'b0;
    key = 24'($urandom);
    check("rdy_fall", 32'(rdy), 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!rdy && n < 3000) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic check_results(input logic [23:0] k);
    int bad;
    model_run(k);
    check("wr_count", 32'(wr_log.size()), 32'd768);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (i >= wr_log.size() || wr_log[i] !== {8'(i), 8'(i)}) bad++;
    check("fill_seq", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= wr_log.size() || wr_log[i] !== exp_q[i]) bad++;
    check("wr_seq", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== model_s[i]) bad++;
    check("final_s", 32'(bad), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'd1281);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [23:0] key;
    logic [95:0] sw;   // first six writes after FILL, {addr,data} each
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [95:0] sw;
    logic [15:0] got;
    n_checks = 0;
    n_fail   = 0;
    busy_cnt = 0;
    en  = 1'b0;
    key = 24'h0;
    rst = 1'b1;

    vecs[0] = '{key: 24'h010203, sw: {16'h0001, 16'h0100, 16'h0103, 16'h0300, 16'h0208, 16'h0802}};
    vecs[1] = '{key: 24'h000000, sw: {16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302}};
    vecs[2] = '{key: 24'h0A0B0C, sw: {16'h000A, 16'h0A00, 16'h0116, 16'h1601, 16'h0224, 16'h2402}};
    vecs[3] = '{key: 24'hFFFFFF, sw: {16'h00FF, 16'hFF00, 16'h0100, 16'hFF01, 16'h02FF, 16'h0002}};

    // reset then idle
    tick();
    check("rst_rdy", 32'(rdy), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("idle_rdy", 32'(rdy), 32'd1);
    check("idle_wren", 32'(s_wren), 32'd0);
    check("idle_addr", 32'(s_addr), 32'd0);
    check("idle_wrdata", 32'(s_wrdata), 32'd0);
    wr_log.delete();
    repeat (50) tick();
    check("idle_no_writes", 32'(wr_log.size()), 32'd0);

    // table-driven full runs
    for (int v = 0; v < 4; v++) begin
      start_run(vecs[v].key);
      wait_done();
      check_results(vecs[v].key);
      sw = vecs[v].sw;
      for (int n = 0; n < 6; n++) begin
        got = (256 + n < wr_log.size()) ? wr_log[256 + n] : 16'hxxxx;
        check($sformatf("swap_k%0d_w%0d", v, n), 32'(got), 32'(sw[95 - 16*n -: 16]));
      end
      tick();
    end

    // en pulses while busy must not restart
    start_run(24'h010203);
    repeat (300) tick();
    en = 1'b1; key = 24'hFFFFFF;
    tick();
    en = 1'b0;
    repeat (400) tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_done();
    check_results(24'h010203);
    tick();

    // en held high: back-to-back runs
    busy_cnt = 0;
    wr_log.delete();
    key = 24'h0A0B0C;
    en  = 1'b1;
    tick();
    check("held_rdy_fall", 32'(rdy), 32'd0);
    wait_done();
    check_results(24'h0A0B0C);
    busy_cnt = 0;
    wr_log.delete();
    tick();
    check("held_restart", 32'(rdy), 32'd0);
    en = 1'b0;
    wait_done();
    check_results(24'h0A0B0C);
    tick();

    // reset mid-scramble, then a clean run
    start_run(24'h010203);
    repeat (700) tick();
    rst = 1'b1;
    #1;
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_wren", 32'(s_wren), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_rdy", 32'(rdy), 32'd1);
    start_run(24'h0A0B0C);
    wait_done();
    check_results(24'h0A0B0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
